// File: rtl/demux_route_ctrl.sv
// -----------------------------------------------------------------------------
// demux_route_ctrl
//
// Queues single-bit data items tagged with a 2-bit destination and presents the
// oldest one to a 1-to-4 demultiplexer: o_a is the demux data input and
// o_sel_code its one-hot select. The head leaves the queue when the addressed
// channel is ready. If that channel stays busy for TIMEOUT consecutive cycles,
// the head is discarded so later traffic is not blocked forever.
//
// Ports
//   i_clk       single clock, rising edge
//   i_n_rst     asynchronous active-low reset
//   i_a         data bit offered upstream
//   i_dest      destination channel 0..3 of the offered bit
//   i_valid     upstream offer present
//   o_ready     offer is accepted this cycle (not full, out of reset)
//   o_a         head data bit (0 when empty)
//   o_sel_code  one-hot head destination (0 when empty)
//   o_valid     head entry present
//   i_ready     per-channel consumer ready, bit n = channel n
//   o_count     number of stored entries, 0..DEPTH
//   o_drop      one-cycle pulse after a head entry was discarded on timeout
// -----------------------------------------------------------------------------
module demux_route_ctrl #(
   parameter int DEPTH   = 4,   // power of two, 2..16
   parameter int TIMEOUT = 15   // stalled cycles before a head drop; 0 = never
) (
   input  logic                     i_clk,
   input  logic                     i_n_rst,
   input  logic                     i_a,
   input  logic [1:0]               i_dest,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic                     o_a,
   output logic [3:0]               o_sel_code,
   output logic                     o_valid,
   input  logic [3:0]               i_ready,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // Counter only has to reach TIMEOUT-1: the edge that would take it to
   // TIMEOUT is the one that drops the head.
   localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef struct packed {
      logic [1:0] dest;
      logic       a;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [SW-1:0]   stall_cnt;
   logic            run;        // set on the first edge after reset release
   logic            drop_q;

   entry_t          head;
   logic            has_head;
   logic            head_ready;
   logic            push;
   logic            deliver;
   logic            timeout_hit;
   logic            pop;

   always_comb begin
      head        = mem[rd_ptr];
      has_head    = (count != '0);
      head_ready  = i_ready[head.dest];
      push        = i_valid && o_ready;
      deliver     = has_head && head_ready;
      // A ready consumer in the timeout cycle takes precedence over the drop.
      timeout_hit = (TIMEOUT > 0) && has_head && !head_ready && (stall_cnt == STALL_LAST);
      pop         = deliver || timeout_hit;
   end

   // Outputs depend only on registered state, never on the upstream offer.
   // o_ready is deliberately blind to a same-cycle pop: a full queue never
   // passes an offer through.
   assign o_ready    = run && (count < CW'(DEPTH));
   assign o_valid    = has_head;
   assign o_a        = has_head && head.a;
   assign o_sel_code = has_head ? (4'b0001 << head.dest) : 4'b0000;
   assign o_count    = count;
   assign o_drop     = drop_q;

   // NOTE: storage is not reset; stale contents are never visible because every
   // output derived from it is gated by a non-zero count.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= entry_t'{dest: i_dest, a: i_a};
      end
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         stall_cnt <= '0;
         run       <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         run    <= 1'b1;
         drop_q <= timeout_hit;

         // Pointer width is log2(DEPTH), so the increment wraps modulo DEPTH.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (pop || !has_head) begin
            stall_cnt <= '0;
         end else if (TIMEOUT > 0) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demux_route_ctrl
//
// Directed bench for demux_route_ctrl (DEPTH=4, TIMEOUT=15). A queue holds the
// entries the bench expects to be stored; every cycle the DUT outputs are
// compared with the queue head, its size and the expected drop/ready state,
// then the queue is advanced with the same push/deliver/drop decisions.
// -----------------------------------------------------------------------------
module tb_demux_route_ctrl;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   typedef struct {
      logic [1:0] dest;
      logic       a;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       a;
   logic [1:0] dest;
   logic       valid;
   logic [3:0] ready;
   logic       o_ready;
   logic       o_a;
   logic [3:0] o_sel_code;
   logic       o_valid;
   logic [2:0] o_count;
   logic       o_drop;

   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t sb[$];
   logic exp_run;
   logic exp_drop;
   int   exp_stall;

   demux_route_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .i_clk      (clk),
      .i_n_rst    (rst_n),
      .i_a        (a),
      .i_dest     (dest),
      .i_valid    (valid),
      .o_ready    (o_ready),
      .o_a        (o_a),
      .o_sel_code (o_sel_code),
      .o_valid    (o_valid),
      .i_ready    (ready),
      .o_count    (o_count),
      .o_drop     (o_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      exp_run   = 1'b0;
      exp_drop  = 1'b0;
      exp_stall = 0;
   endtask

   task automatic check_outputs(input string tag);
      logic       e_valid;
      logic       e_a;
      logic [3:0] e_sel;
      e_valid = (sb.size() != 0);
      e_a     = e_valid ? sb[0].a : 1'b0;
      e_sel   = e_valid ? (4'b0001 << sb[0].dest) : 4'b0000;
      check({tag, " o_count"},    32'(o_count),    32'(sb.size()));
      check({tag, " o_valid"},    32'(o_valid),    32'(e_valid));
      check({tag, " o_a"},        32'(o_a),        32'(e_a));
      check({tag, " o_sel_code"}, 32'(o_sel_code), 32'(e_sel));
      check({tag, " o_ready"},    32'(o_ready),    32'(exp_run && sb.size() < DEPTH));
      check({tag, " o_drop"},     32'(o_drop),     32'(exp_drop));
   endtask

   // One clock cycle: drive inputs just after a falling edge, compare outputs,
   // advance the expected state, then move on to the next falling edge.
   task automatic step(input string tag, input logic v, input logic d_a,
                       input logic [1:0] d, input logic [3:0] r);
      logic do_push;
      logic do_deliver;
      logic do_drop;
      exp_t e;
      valid = v;
      a     = d_a;
      dest  = d;
      ready = r;
      #1;
      check_outputs(tag);
      do_push    = v && exp_run && (sb.size() < DEPTH);
      do_deliver = (sb.size() != 0) && r[sb[0].dest];
      do_drop    = (sb.size() != 0) && !do_deliver && (exp_stall == TIMEOUT - 1);
      if (sb.size() == 0 || do_deliver || do_drop) exp_stall = 0;
      else                                         exp_stall++;
      if (do_deliver || do_drop) void'(sb.pop_front());
      if (do_push) begin
         e.dest = d;
         e.a    = d_a;
         sb.push_back(e);
      end
      exp_drop = do_drop;
      exp_run  = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input string tag, input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 2'd0, r);
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      a     = 1'b0;
      dest  = 2'd0;
      ready = 4'b0000;
      model_reset();

      // Reset state while clocks run.
      #1;
      check_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset held");

      // Release between edges: o_ready stays low until the first rising edge.
      rst_n = 1'b1;
      step("post release", 1'b0, 1'b0, 2'd0, 4'b0000);
      idle("first ready", 4'b0000, 1);

      // Single entry to channel 2 with every consumer busy.
      step("push d2", 1'b1, 1'b1, 2'd2, 4'b0000);
      idle("hold d2", 4'b0000, 2);
      idle("drain d2", 4'b1111, 2);

      // One entry per channel, all consumers ready.
      step("route d0", 1'b1, 1'b1, 2'd0, 4'b1111);
      step("route d1", 1'b1, 1'b0, 2'd1, 4'b1111);
      step("route d2", 1'b1, 1'b1, 2'd2, 4'b1111);
      step("route d3", 1'b1, 1'b0, 2'd3, 4'b1111);
      idle("route drain", 4'b1111, 3);

      // Fill to DEPTH, hold a fifth offer, pop while full, then push+pop at 2.
      step("fill 0", 1'b1, 1'b0, 2'd0, 4'b0000);
      step("fill 1", 1'b1, 1'b1, 2'd1, 4'b0000);
      step("fill 2", 1'b1, 1'b0, 2'd2, 4'b0000);
      step("fill 3", 1'b1, 1'b1, 2'd3, 4'b0000);
      step("full hold", 1'b1, 1'b1, 2'd3, 4'b0000);
      step("full hold", 1'b1, 1'b1, 2'd3, 4'b0000);
      step("full pop", 1'b1, 1'b1, 2'd3, 4'b0001);   // pop, offer still refused
      step("refill", 1'b1, 1'b1, 2'd3, 4'b0000);     // fifth entry accepted
      step("wrong ch", 1'b0, 1'b0, 2'd0, 4'b1101);   // head on ch1: no pop
      step("to 3", 1'b0, 1'b0, 2'd0, 4'b0010);
      step("to 2", 1'b0, 1'b0, 2'd0, 4'b0100);
      step("push+pop @2", 1'b1, 1'b0, 2'd0, 4'b1000);
      idle("fill drain", 4'b1111, 4);

      // Timeout drop of a channel-1 head, then the next entry goes out.
      step("to push d1", 1'b1, 1'b1, 2'd1, 4'b1101);
      step("to push d3", 1'b1, 1'b0, 2'd3, 4'b1101);
      idle("to stall", 4'b1101, 18);

      // Same head, consumer becomes ready exactly in the timeout cycle.
      step("tr push d1", 1'b1, 1'b0, 2'd1, 4'b1101);
      idle("tr stall", 4'b1101, 14);
      step("tr ready", 1'b0, 1'b0, 2'd0, 4'b1111);
      idle("tr after", 4'b1111, 2);

      // Pointer wrap: ten push/pop pairs through the four entries.
      for (int i = 0; i < 10; i++) begin
         logic [1:0] rd;
         logic       ra;
         rd = 2'($urandom_range(0, 3));
         ra = 1'($urandom_range(0, 1));
         step("wrap", 1'b1, ra, rd, 4'b1111);
      end
      idle("wrap drain", 4'b1111, 2);

      // Reset mid-cycle with three entries stored.
      step("pre rst 0", 1'b1, 1'b1, 2'd0, 4'b0000);
      step("pre rst 1", 1'b1, 1'b1, 2'd1, 4'b0000);
      step("pre rst 2", 1'b1, 1'b1, 2'd2, 4'b0000);
      valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("mid reset");
      @(negedge clk);
      check_outputs("mid reset held");
      rst_n = 1'b1;
      idle("after release", 4'b1111, 3);
      step("new push", 1'b1, 1'b0, 2'd3, 4'b0000);
      idle("new hold", 4'b0000, 1);
      idle("new drain", 4'b1111, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
